wam_scorer: RTL and testbench

- Downstream stage of the whack-a-mole light flicker: it consumes the "mole up / mole down" events for the lit LEDR index and the player's switch inputs.
- Detects hits, wrong whacks and misses, then keeps score and lives and flags game over.
- Drives an early-clear pulse back to the flicker so a whacked light goes dark immediately.
- Score and lives feed the HEX display stage.

---
 rtl/wam_pkg.sv | 16 +
 rtl/sw_sync_edge.sv | 31 +++
 rtl/wam_scorer.sv | 173 +++++++++++++++++
 tb/tb_wam_scorer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared constants and FSM encoding for the whack-a-mole scorer.
// Optional streak bonus is enabled by defining WAM_STREAK_BONUS_EN.
package wam_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UP      = 2'd1,
        ST_WHACKED = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam int MOLE_COUNT    = 9;
    localparam int IDX_W         = 4;
    localparam int DEF_LIVES     = 3;
    localparam int DEF_SCORE_W   = 10;
    localparam int DEF_SCORE_MAX = 999;
endpackage

// File: rtl/sw_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detect for a bus of switches.
// Flops clear to 0, so the first cycles after reset see a held switch as low.
module sw_sync_edge #(
    parameter int W = 9
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_edge
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;
    logic [W-1:0] r_edge;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_meta <= i_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync & ~r_prev;
        end
    end

    assign o_edge = r_edge;
endmodule

// File: rtl/wam_scorer.sv
// Whack-a-mole scorer: turns mole events and switch edges into hits, misses,
// wrong whacks, score, lives and game over. Streak bonus under WAM_STREAK_BONUS_EN.
module wam_scorer
    import wam_pkg::*;
#(
    parameter int LIVES     = DEF_LIVES,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mole_on,
    input  logic [IDX_W-1:0]      mole_idx,
    input  logic                  mole_off,
    input  logic [MOLE_COUNT-1:0] hit_sw,
    output logic [SCORE_W-1:0]    score,
    output logic [3:0]            lives,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  wrong_pulse,
    output logic                  mole_clear,
    output logic                  game_over
);
    state_t                r_state, n_state;
    logic [SCORE_W-1:0]    r_score, n_score;
    logic [3:0]            r_lives, n_lives;
    logic [IDX_W-1:0]      r_idx, n_idx;
    logic                  r_off_pend, n_off_pend;
    logic                  r_hit, r_miss, r_wrong, r_clear, r_over;
    logic                  w_hit, w_miss, w_wrong;
    logic [MOLE_COUNT-1:0] w_edge;
    logic                  w_idx_ok, w_any_edge, w_cur_edge;
    logic [SCORE_W:0]      w_inc, w_sum, w_diff;
    logic [SCORE_W-1:0]    w_score_up, w_score_dn;
    logic [3:0]            w_lives_dec;

    sw_sync_edge #(.W(MOLE_COUNT)) u_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .i_in     (hit_sw),
        .o_edge   (w_edge)
    );

`ifdef WAM_STREAK_BONUS_EN
    logic [2:0] r_streak;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            r_streak <= '0;
        else if (start || w_miss || w_wrong)
            r_streak <= '0;
        else if (w_hit && r_streak != 3'd7)
            r_streak <= r_streak + 3'd1;
    end

    assign w_inc = (r_streak >= 3'd3) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1);
`else
    assign w_inc = (SCORE_W+1)'(1);
`endif

    assign w_idx_ok    = mole_on && (mole_idx < IDX_W'(MOLE_COUNT));
    assign w_any_edge  = |w_edge;
    assign w_cur_edge  = |(w_edge & (MOLE_COUNT'(1) << r_idx));
    assign w_sum       = {1'b0, r_score} + w_inc;
    assign w_score_up  = (w_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : w_sum[SCORE_W-1:0];
    assign w_diff      = {1'b0, r_score} - (SCORE_W+1)'(1);
    assign w_score_dn  = w_diff[SCORE_W] ? '0 : w_diff[SCORE_W-1:0];
    assign w_lives_dec = (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;

    always_comb begin
        n_state    = r_state;
        n_score    = r_score;
        n_lives    = r_lives;
        n_idx      = r_idx;
        n_off_pend = 1'b0;
        w_hit      = 1'b0;
        w_miss     = 1'b0;
        w_wrong    = 1'b0;
        if (start) begin
            n_state = ST_IDLE;
            n_score = '0;
            n_lives = 4'(LIVES);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_edge) begin
                        w_wrong = 1'b1;
                        n_score = w_score_dn;
                    end
                    if (w_idx_ok) begin
                        n_idx   = mole_idx;
                        n_state = ST_UP;
                    end
                end
                ST_UP: begin
                    if (w_cur_edge) begin
                        // A hit beats a coincident mole_off; remember the off for WHACKED.
                        w_hit      = 1'b1;
                        n_score    = w_score_up;
                        n_state    = ST_WHACKED;
                        n_off_pend = mole_off;
                        if (w_idx_ok) begin
                            n_idx   = mole_idx;
                            n_state = ST_UP;
                        end
                    end else begin
                        if (w_any_edge) begin
                            w_wrong = 1'b1;
                            n_score = w_score_dn;
                        end
                        if (mole_off || w_idx_ok) begin
                            w_miss  = 1'b1;
                            n_lives = w_lives_dec;
                            if (w_lives_dec == 4'd0) begin
                                n_state = ST_OVER;
                            end else if (w_idx_ok) begin
                                n_idx   = mole_idx;
                                n_state = ST_UP;
                            end else begin
                                n_state = ST_IDLE;
                            end
                        end
                    end
                end
                ST_WHACKED: begin
                    if (w_idx_ok) begin
                        n_idx   = mole_idx;
                        n_state = ST_UP;
                    end else if (mole_off || r_off_pend) begin
                        n_state = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_score    <= '0;
            r_lives    <= 4'(LIVES);
            r_idx      <= '0;
            r_off_pend <= 1'b0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_wrong    <= 1'b0;
            r_clear    <= 1'b0;
            r_over     <= 1'b0;
        end else begin
            r_state    <= n_state;
            r_score    <= n_score;
            r_lives    <= n_lives;
            r_idx      <= n_idx;
            r_off_pend <= n_off_pend;
            r_hit      <= w_hit;
            r_miss     <= w_miss;
            r_wrong    <= w_wrong;
            r_clear    <= w_hit;
            r_over     <= (n_state == ST_OVER);
        end
    end

    assign score       = r_score;
    assign lives       = r_lives;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign wrong_pulse = r_wrong;
    assign mole_clear  = r_clear;
    assign game_over   = r_over;
endmodule

// File: tb/tb_wam_scorer.sv
// Directed bench for wam_scorer: a default instance plus a SCORE_MAX=5 instance
// sharing the same stimulus. Expected values for the streak build are selected by macro.
module tb_wam_scorer;
    import wam_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mole_on = 1'b0;
    logic [3:0] mole_idx = '0;
    logic       mole_off = 1'b0;
    logic [8:0] hit_sw = '0;

    logic [9:0] score, score_s;
    logic [3:0] lives, lives_s;
    logic       hit_pulse, miss_pulse, wrong_pulse, mole_clear, game_over;
    logic       hit_s, miss_s, wrong_s, clear_s, over_s;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_main[6];
    int exp_sat[6];

    wam_scorer dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .mole_on(mole_on),
        .mole_idx(mole_idx), .mole_off(mole_off), .hit_sw(hit_sw),
        .score(score), .lives(lives), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .wrong_pulse(wrong_pulse), .mole_clear(mole_clear), .game_over(game_over)
    );

    wam_scorer #(.SCORE_MAX(5)) dut_sat (
        .CLOCK_50(clk), .reset(reset), .start(start), .mole_on(mole_on),
        .mole_idx(mole_idx), .mole_off(mole_off), .hit_sw(hit_sw),
        .score(score_s), .lives(lives_s), .hit_pulse(hit_s), .miss_pulse(miss_s),
        .wrong_pulse(wrong_s), .mole_clear(clear_s), .game_over(over_s)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_watch(input int n, output int hits, output int wrongs);
        hits = 0;
        wrongs = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            hits   += int'(hit_pulse);
            wrongs += int'(wrong_pulse);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_mole_on(input logic [3:0] idx);
        mole_idx = idx;
        mole_on  = 1'b1;
        tick(1);
        mole_on  = 1'b0;
    endtask

    task automatic do_mole_off();
        mole_off = 1'b1;
        tick(1);
        mole_off = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_checks++;
        if (score !== 10'd0 || lives !== 4'd3 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: score=%0d lives=%0d over=%0b, want 0/3/0", score, lives, game_over);
        end
        n_checks++;
        if ({hit_pulse, miss_pulse, wrong_pulse, mole_clear} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 0000", {hit_pulse, miss_pulse, wrong_pulse, mole_clear});
        end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_hit();
        int h, w;
        do_start();
        do_mole_on(4'd4);
        hit_sw[4] = 1'b1;
        tick(3);
        n_checks++;
        if (hit_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_early: hit_pulse=%b at cycle 3, want 0", hit_pulse);
        end
        tick(1);
        n_checks++;
        if (hit_pulse !== 1'b1 || mole_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_latency: hit=%b clear=%b, want 1/1", hit_pulse, mole_clear);
        end
        tick(1);
        n_checks++;
        if (score !== 10'd1 || hit_pulse !== 1'b0 || dut.r_state !== ST_WHACKED) begin
            n_fail++;
            $display("FAIL hit_score: score=%0d hit=%b state=%0d, want 1/0/WHACKED", score, hit_pulse, dut.r_state);
        end
        hit_sw[4] = 1'b0;
        tick(3);
        hit_sw[4] = 1'b1;
        tick_watch(6, h, w);
        n_checks++;
        if (h !== 0 || w !== 0 || score !== 10'd1) begin
            n_fail++;
            $display("FAIL no_double_hit: hits=%0d wrongs=%0d score=%0d, want 0/0/1", h, w, score);
        end
        do_mole_off();
        hit_sw = '0;
        tick(4);
    endtask

    task automatic test_miss();
        int h, w;
        do_start();
        for (int k = 0; k < 3; k++) begin
            do_mole_on(4'd2);
            tick(2);
            do_mole_off();
            n_checks++;
            if (miss_pulse !== 1'b1 || lives !== 4'(2 - k)) begin
                n_fail++;
                $display("FAIL miss_%0d: miss=%b lives=%0d, want 1/%0d", k, miss_pulse, lives, 2 - k);
            end
        end
        tick(1);
        n_checks++;
        if (game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL game_over: got %b want 1", game_over);
        end
        do_mole_on(4'd1);
        hit_sw[1] = 1'b1;
        tick_watch(6, h, w);
        n_checks++;
        if (h !== 0 || w !== 0 || score !== 10'd0 || game_over !== 1'b1 || lives !== 4'd0) begin
            n_fail++;
            $display("FAIL over_ignores: hits=%0d wrongs=%0d score=%0d over=%b lives=%0d, want 0/0/0/1/0",
                     h, w, score, game_over, lives);
        end
        hit_sw = '0;
        tick(4);
        do_start();
        n_checks++;
        if (lives !== 4'd3 || game_over !== 1'b0 || score !== 10'd0) begin
            n_fail++;
            $display("FAIL restart: lives=%0d over=%b score=%0d, want 3/0/0", lives, game_over, score);
        end
    endtask

    task automatic test_wrong();
        do_start();
        do_mole_on(4'd5);
        hit_sw[7] = 1'b1;
        tick(4);
        n_checks++;
        if (wrong_pulse !== 1'b1 || score !== 10'd0 || hit_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_floor: wrong=%b score=%0d hit=%b, want 1/0/0", wrong_pulse, score, hit_pulse);
        end
        hit_sw[5] = 1'b1;
        tick(4);
        n_checks++;
        if (hit_pulse !== 1'b1 || wrong_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_then_hit: hit=%b wrong=%b, want 1/0", hit_pulse, wrong_pulse);
        end
        tick(1);
        n_checks++;
        if (score !== 10'd1) begin
            n_fail++;
            $display("FAIL wrong_then_hit_score: score=%0d want 1", score);
        end
        do_mole_off();
        hit_sw = '0;
        tick(4);
    endtask

    task automatic test_simultaneous();
        do_start();
        do_mole_on(4'd3);
        hit_sw[3] = 1'b1;
        tick(3);
        do_mole_off();
        n_checks++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || lives !== 4'd3) begin
            n_fail++;
            $display("FAIL hit_and_off: hit=%b miss=%b lives=%0d, want 1/0/3", hit_pulse, miss_pulse, lives);
        end
        tick(1);
        n_checks++;
        if (dut.r_state !== ST_IDLE || miss_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_and_off_idle: state=%0d miss=%b, want IDLE/0", dut.r_state, miss_pulse);
        end
        hit_sw = '0;
        tick(4);
    endtask

    task automatic test_saturation();
        do_start();
        for (int k = 0; k < 6; k++) begin
            do_mole_on(4'd0);
            hit_sw[0] = 1'b1;
            tick(5);
            n_checks++;
            if (score !== 10'(exp_main[k]) || score_s !== 10'(exp_sat[k])) begin
                n_fail++;
                $display("FAIL score_hit_%0d: main=%0d sat=%0d, want %0d/%0d",
                         k + 1, score, score_s, exp_main[k], exp_sat[k]);
            end
            do_mole_off();
            hit_sw[0] = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_reset_mid();
        int h, w;
        do_mole_on(4'd0);
        hit_sw[0] = 1'b1;
        tick(2);
        reset = 1'b0;
        #2;
        n_checks++;
        if (score !== 10'd0 || lives !== 4'd3 || game_over !== 1'b0 || dut.r_state !== ST_IDLE ||
            {hit_pulse, miss_pulse, wrong_pulse, mole_clear} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: score=%0d lives=%0d over=%b state=%0d, want 0/3/0/IDLE",
                     score, lives, game_over, dut.r_state);
        end
        tick(2);
        reset = 1'b1;
        tick(5);
        do_mole_on(4'd0);
        tick_watch(8, h, w);
        n_checks++;
        if (h !== 0 || score !== 10'd0) begin
            n_fail++;
            $display("FAIL held_sw_no_hit: hits=%0d score=%0d, want 0/0", h, score);
        end
        hit_sw = '0;
        tick(2);
    endtask

    initial begin
`ifdef WAM_STREAK_BONUS_EN
        exp_main = '{1, 2, 3, 5, 7, 9};
        exp_sat  = '{1, 2, 3, 5, 5, 5};
`else
        exp_main = '{1, 2, 3, 4, 5, 6};
        exp_sat  = '{1, 2, 3, 4, 5, 5};
`endif
        test_reset();
        test_hit();
        test_miss();
        test_wrong();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
